// File: rtl/latch_write_arbiter.sv
// Round-robin write arbiter for a bank of transparent word latches.
// Sequences setup/enable/hold so lat_data never moves while a latch is open.
module latch_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int NREG      = 4,
    parameter int EN_CYCLES = 2,
    localparam int AW       = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*16-1:0]   wdata,
    input  logic [NREQ*AW-1:0]   waddr,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic                 busy,
    output logic [15:0]          lat_data,
    output logic [NREG-1:0]      lat_en
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ENABLE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] cap_idx;
    logic [AW-1:0] cap_addr;
    logic [3:0]    cnt;

    logic [15:0]   wd [NREQ];
    logic [AW-1:0] wa [NREQ];
    logic [NREG-1:0] en_mask;
    logic [NREQ-1:0] ack_mask;

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign wd[g]       = wdata[16*g +: 16];
        assign wa[g]       = waddr[AW*g +: AW];
        assign ack_mask[g] = (cap_idx == PW'(g));
    end

    // An out-of-range address matches no bit, so the mask is all-zero.
    for (genvar g = 0; g < NREG; g++) begin : g_reg
        assign en_mask[g] = (cap_addr == AW'(g));
    end

    logic [PW-1:0] win_idx;
    logic          win_vld;

    always_comb begin
        int unsigned cand;
        logic [PW-1:0] cand_idx;
        win_idx  = '0;
        win_vld  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand     = (32'(ptr) + off) % NREQ;
            cand_idx = PW'(cand);
            if (!win_vld && req[cand_idx]) begin
                win_vld = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            cap_idx  <= '0;
            cap_addr <= '0;
            cnt      <= '0;
            ack      <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            lat_en   <= '0;
            lat_data <= '0;
        end else begin
            ack <= '0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        lat_data <= wd[win_idx];
                        cap_addr <= wa[win_idx];
                        cap_idx  <= win_idx;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    lat_en <= en_mask;
                    cnt    <= 4'(EN_CYCLES - 1);
                    state  <= ENABLE;
                end
                ENABLE: begin
                    if (cnt == '0) begin
                        lat_en <= '0;
                        ack    <= ack_mask;
                        err    <= ~|en_mask;
                        state  <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    busy  <= 1'b0;
                    ptr   <= (cap_idx == PW'(NREQ - 1)) ? '0 : cap_idx + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed bench for latch_write_arbiter: three builds (default, NREG=3/EN=1, EN=15)
// with a behavioural latch bank on each.
module tb_latch_write_arbiter;

    logic clk;
    logic rst_n;

    logic [3:0]  req_v   [3];
    logic [63:0] wdata_v [3];
    logic [7:0]  waddr_v [3];
    logic [3:0]  ack_v   [3];
    logic        err_v   [3];
    logic        busy_v  [3];
    logic [15:0] ld_v    [3];
    logic [3:0]  len_v   [3];
    logic [2:0]  len_b;

    assign len_v[1] = {1'b0, len_b};

    latch_write_arbiter #(.NREQ(4), .NREG(4), .EN_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_v[0]), .wdata(wdata_v[0]), .waddr(waddr_v[0]),
        .ack(ack_v[0]), .err(err_v[0]), .busy(busy_v[0]), .lat_data(ld_v[0]), .lat_en(len_v[0])
    );

    latch_write_arbiter #(.NREQ(4), .NREG(3), .EN_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_v[1]), .wdata(wdata_v[1]), .waddr(waddr_v[1]),
        .ack(ack_v[1]), .err(err_v[1]), .busy(busy_v[1]), .lat_data(ld_v[1]), .lat_en(len_b)
    );

    latch_write_arbiter #(.NREQ(4), .NREG(4), .EN_CYCLES(15)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_v[2]), .wdata(wdata_v[2]), .waddr(waddr_v[2]),
        .ack(ack_v[2]), .err(err_v[2]), .busy(busy_v[2]), .lat_data(ld_v[2]), .lat_en(len_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latch bank model: contents survive reset.
    logic [15:0] lreg [3][4] = '{default: '{default: 16'h0000}};
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 4; r++)
                if (len_v[k][r]) lreg[k][r] <= ld_v[k];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int         k;
        int         r;
        logic [15:0] d;
        logic [1:0]  a;
        int         en;
        logic [3:0]  exp_en;
        logic [3:0]  exp_ack;
        logic        exp_err;
        logic        scr;
    } vec_t;

    vec_t tbl [7];

    task automatic do_write(input vec_t v);
        logic [15:0] snap [4];
        logic [15:0] expr;
        for (int i = 0; i < 4; i++) snap[i] = lreg[v.k][i];
        req_v[v.k][v.r]             = 1'b1;
        wdata_v[v.k][16*v.r +: 16]  = v.d;
        waddr_v[v.k][2*v.r +: 2]    = v.a;
        @(posedge clk); #1;
        chk("setup_busy", busy_v[v.k], 1);
        chk("setup_en",   len_v[v.k], 0);
        chk("setup_data", ld_v[v.k], v.d);
        chk("setup_ack",  ack_v[v.k], 0);
        for (int c = 0; c < v.en; c++) begin
            @(posedge clk); #1;
            chk("enable_en",   len_v[v.k], v.exp_en);
            chk("enable_data", ld_v[v.k], v.d);
            chk("enable_ack",  ack_v[v.k], 0);
            if (v.scr && c == 0) begin
                wdata_v[v.k][16*v.r +: 16] = 16'hFFFF;
                waddr_v[v.k][2*v.r +: 2]   = ~v.a;
            end
        end
        @(posedge clk); #1;
        chk("hold_ack",  ack_v[v.k], v.exp_ack);
        chk("hold_err",  err_v[v.k], v.exp_err);
        chk("hold_en",   len_v[v.k], 0);
        chk("hold_data", ld_v[v.k], v.d);
        chk("hold_busy", busy_v[v.k], 1);
        req_v[v.k][v.r] = 1'b0;
        @(posedge clk); #1;
        chk("idle_ack",  ack_v[v.k], 0);
        chk("idle_err",  err_v[v.k], 0);
        chk("idle_busy", busy_v[v.k], 0);
        chk("idle_data", ld_v[v.k], v.d);
        for (int i = 0; i < 4; i++) begin
            expr = v.exp_en[i] ? v.d : snap[i];
            chk("latch_reg", lreg[v.k][i], expr);
        end
    endtask

    int who [$];
    int at  [$];
    int overlap;

    initial begin
        tbl[0] = '{0, 2, 16'hBEEF, 2'd1,  2, 4'b0010, 4'b0100, 1'b0, 1'b0};
        tbl[1] = '{0, 0, 16'h1111, 2'd3,  2, 4'b1000, 4'b0001, 1'b0, 1'b0};
        tbl[2] = '{0, 0, 16'h1234, 2'd0,  2, 4'b0001, 4'b0001, 1'b0, 1'b1};
        tbl[3] = '{1, 1, 16'hA5A5, 2'd3,  1, 4'b0000, 4'b0010, 1'b1, 1'b0};
        tbl[4] = '{1, 0, 16'h5A5A, 2'd2,  1, 4'b0100, 4'b0001, 1'b0, 1'b0};
        tbl[5] = '{2, 3, 16'hCAFE, 2'd0, 15, 4'b0001, 4'b1000, 1'b0, 1'b0};
        tbl[6] = '{2, 1, 16'h0F0F, 2'd2, 15, 4'b0100, 4'b0010, 1'b0, 1'b0};

        for (int k = 0; k < 3; k++) begin
            req_v[k] = '0; wdata_v[k] = '0; waddr_v[k] = '0;
        end
        rst_n = 1'b0;
        #12;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ack",  ack_v[k], 0);
            chk("rst_err",  err_v[k], 0);
            chk("rst_busy", busy_v[k], 0);
            chk("rst_en",   len_v[k], 0);
            chk("rst_data", ld_v[k], 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) do_write(tbl[i]);

        // Reset during the second ENABLE cycle of a write from requester 1.
        req_v[0] = 4'b0010;
        wdata_v[0][31:16] = 16'h7777;
        waddr_v[0][3:2]   = 2'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_en_before", len_v[0], 4'b0100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en",   len_v[0], 0);
        chk("mid_rst_busy", busy_v[0], 0);
        chk("mid_rst_ack",  ack_v[0], 0);
        @(posedge clk); #1;
        chk("mid_rst_noack", ack_v[0], 0);

        // Everyone requests continuously from release: grants must rotate from 0.
        req_v[0]   = 4'b1111;
        wdata_v[0] = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        waddr_v[0] = {2'd3, 2'd2, 2'd1, 2'd0};
        #2 rst_n = 1'b1;
        overlap = 0;
        for (int c = 0; c < 40 && at.size() < 5; c++) begin
            @(posedge clk); #1;
            if ($countones(len_v[0]) > 1) overlap++;
            if (ack_v[0] != '0) begin
                for (int i = 0; i < 4; i++) if (ack_v[0][i]) who.push_back(i);
                at.push_back(c);
                if (at.size() == 5) req_v[0] = '0;
            end
        end
        chk("rr_ack_count", at.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("rr_grant_order", (i < who.size()) ? who[i] : 99, i % 4);
            chk("rr_ack_cycle",   (i < at.size())  ? at[i]  : 999, 3 + 5 * i);
        end
        chk("rr_en_overlap", overlap, 0);
        @(posedge clk); #1;
        chk("rr_idle_busy", busy_v[0], 0);
        for (int i = 0; i < 4; i++) chk("rr_latch_reg", lreg[0][i], 16'h1111 * i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
